// File: rtl/rf_dump_ctrl_if.sv
//==============================================================================
// Module   : rf_dump_ctrl_if
// Brief    : Valid/ready beat stream carrying one register-file dump word.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface rf_dump_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_chk;
  logic        out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_chk,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_chk,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/rf_dump_ctrl.sv
//==============================================================================
// Module   : rf_dump_ctrl
// Brief    : Walks the core debug read port after finish and streams each
//            register. Optional trailing checksum beat: RF_DUMP_CHECKSUM_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rf_dump_ctrl #(
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  finish,
  output logic [4:0]            rdtaddr,
  input  logic [31:0]           rdtdata,
  rf_dump_ctrl_if.master        out_if,
  output logic                  busy,
  output logic                  done
);

  localparam logic [4:0] c_last_idx = 5'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
`ifdef RF_DUMP_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_finish_d;
  logic [4:0]  r_idx;
  logic        r_valid;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic        r_last;
`ifdef RF_DUMP_CHECKSUM_EN
  logic        r_chk;
  logic [31:0] r_sum;
`endif

  logic w_start;
  logic w_accept;
  logic w_at_last;

  assign w_start   = finish & ~r_finish_d;
  assign w_accept  = r_valid & out_if.out_ready;
  // Terminal compare precedes the increment, so idx never wraps at NREG=32.
  assign w_at_last = (r_idx == c_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_finish_d <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_finish_d <= finish;
    end
  end

  always_comb begin
    w_next_state = r_state;
    rdtaddr      = 5'd0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_READ;
      end
      S_READ: begin
        busy         = 1'b1;
        rdtaddr      = r_idx;
        w_next_state = S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (w_accept) begin
          if (!w_at_last) begin
            w_next_state = S_READ;
          end else begin
`ifdef RF_DUMP_CHECKSUM_EN
            w_next_state = S_CHK;
`else
            w_next_state = S_DONE;
`endif
          end
        end
      end
`ifdef RF_DUMP_CHECKSUM_EN
      S_CHK: begin
        busy = 1'b1;
        if (w_accept) w_next_state = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (!finish) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 5'd0;
      r_valid <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_last  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      r_chk   <= 1'b0;
      r_sum   <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_idx <= 5'd0;
`ifdef RF_DUMP_CHECKSUM_EN
            r_sum <= 32'd0;
`endif
          end
        end
        S_READ: begin
          // Sampled here only; later core writes do not disturb a stalled beat.
          r_data  <= rdtdata;
          r_addr  <= r_idx;
          r_valid <= 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
          r_chk   <= 1'b0;
          r_last  <= 1'b0;
`else
          r_last  <= w_at_last;
`endif
        end
        S_SEND: begin
          if (w_accept) begin
            if (!w_at_last) begin
              r_idx   <= r_idx + 5'd1;
              r_valid <= 1'b0;
            end else begin
`ifdef RF_DUMP_CHECKSUM_EN
              // Valid stays high: the checksum beat follows immediately.
              r_data  <= r_sum + r_data;
              r_addr  <= 5'd0;
              r_chk   <= 1'b1;
              r_last  <= 1'b1;
`else
              r_valid <= 1'b0;
`endif
            end
`ifdef RF_DUMP_CHECKSUM_EN
            r_sum <= r_sum + r_data;
`endif
          end
        end
`ifdef RF_DUMP_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) r_valid <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_addr  = r_addr;
  assign out_if.out_data  = r_data;
  assign out_if.out_last  = r_last;
`ifdef RF_DUMP_CHECKSUM_EN
  assign out_if.out_chk   = r_chk;
`else
  assign out_if.out_chk   = 1'b0;
`endif

endmodule

`default_nettype wire
